mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch port and the load/store data port of the RV32 core.
- Sequences each access: grant, memory read-latency wait, and completion.
- Generates per-port stall signals that freeze the PC and pipeline while a request is pending.
- Sits between the core (fetch and MEM stage) and the memory macro.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- MEM_LAT, 1, memory read latency in cycles (legal 1..4).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held with if_addr stable until if_done.
- if_addr  in  ADDR_W  fetch byte address.
- if_done  out  1  fetch complete; if_rdata valid this cycle.
- if_rdata  out  DATA_W  fetched instruction.
- if_stall  out  1  if_req & ~if_done.
- d_req  in  1  data request; held with all d_* inputs stable until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  DATA_W  store data.
- d_be  in  DATA_W/8  byte enables for stores.
- d_done  out  1  data access complete; d_rdata valid this cycle for loads.
- d_rdata  out  DATA_W  load data.
- d_stall  out  1  d_req & ~d_done.
- mem_en  out  1  memory access strobe, one cycle per access.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_be  out  DATA_W/8  memory byte enables.
- mem_rdata  in  DATA_W  read data, valid MEM_LAT cycles after a read strobe.

Behaviour:
- State machine:
  - IDLE: arbitration allowed.
  - RD_WAIT: one read outstanding; a wait counter runs.
  - Owner register records which port owns the outstanding read: 0 = fetch, 1 = data.
- Reset (synchronous):
  - State IDLE, counter 0, owner 0.
  - All outputs 0: mem_en, mem_we, mem_addr, mem_wdata, mem_be, if_done, d_done, if_rdata, d_rdata.
  - Stalls follow their equations, so if_stall = if_req and d_stall = d_req.
- Arbitration in IDLE:
  - If d_req, data is granted; else if if_req, fetch is granted. Data has fixed priority.
  - The grant is combinational in the same cycle.
- Granted cycle:
  - mem_en = 1.
  - mem_addr = the granted port's address.
  - Fetch grant: mem_we = 0 and mem_be = all ones.
  - Data grant: mem_we = d_we, mem_be = d_be, mem_wdata = d_wdata.
- Store grant: d_done = 1 in the same cycle and the state stays IDLE, so back-to-back stores run at 1 per cycle.
- Read grant (fetch or data load):
  - Next state is RD_WAIT, counter loads 1, owner is recorded.
  - mem_en is 0 throughout RD_WAIT.
- RD_WAIT:
  - While counter < MEM_LAT, the counter increments each cycle.
  - When counter == MEM_LAT, the owner's done = 1 and the owner's rdata = mem_rdata. Next state is IDLE.
  - Read latency seen by the core is MEM_LAT cycles after the grant. Read throughput is one access per MEM_LAT+1 cycles.
- Completion handshake: the requester observes done in cycle N and updates or drops req at edge N→N+1. The arbiter re-arbitrates on the new request values in IDLE at N+1.
- The non-owner port stays stalled during RD_WAIT regardless of its request.
- Simultaneous if_req and d_req in IDLE: data is served. Fetch is served on the first IDLE cycle where d_req = 0.
- if_rdata and d_rdata are 0 in any cycle where the respective done is 0.
- Address alignment is not checked; addresses pass through unchanged.
- A request dropped before done is a protocol violation and is not supported.
- Reset during RD_WAIT: the FSM returns to IDLE and no done is issued. A mem_rdata arriving later is ignored.

Optional Feature:
- Macro ARB_RR_EN.
- Defined: a last-served register (reset 0 = fetch). On a simultaneous if_req and d_req in IDLE, grant the port not served last. The register updates on every grant.
- Undefined: fixed data-over-fetch priority; no last-served register.

Test Plan:
- Reset, then if_req = 1, if_addr = 0x0000_0010, MEM_LAT = 1 → mem_en = 1 with mem_addr = 0x10 in cycle 0; if_done = 1 with if_rdata = mem_rdata in cycle 1; IDLE in cycle 2.
- Store d_req = 1, d_we = 1, d_addr = 0x100, d_wdata = 0xDEADBEEF, d_be = 4'b0011 → same-cycle mem_we = 1, mem_be = 0011, d_done = 1. A second store to 0x104 on the next cycle completes back-to-back.
- if_req and d_req (load from 0x200) asserted together, macro off → data is granted first. Fetch is granted at cycle 2 with if_stall = 1 in cycles 0–2. With ARB_RR_EN and last-served = data, fetch is granted first.
- MEM_LAT = 3 load from 0x40 → d_done only in cycle 3 after the grant; mem_en = 0 in cycles 1–3; d_stall = 1 in cycles 0–2.
- Assert rst in cycle 1 of a MEM_LAT = 3 read → no done pulse; state IDLE; mem_rdata returning in cycle 3 does not appear on either rdata port.
- Sustained d_req with if_req held for 5 cycles of stores (macro off) → if_done stays 0 until d_req drops, then the fetch is granted in the next IDLE cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between the fetch port and the load/store port.
// Optional build macro ARB_RR_EN: alternate grants on simultaneous requests instead of fixed data priority.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_done,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_stall,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_done,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_stall,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata
);

    typedef enum logic {IDLE, RD_WAIT} state_t;

    localparam logic [2:0] LAT = 3'(MEM_LAT);

    state_t     state, state_next;
    logic [2:0] cnt, cnt_next;
    logic       owner, owner_next;
    logic       grant_d, grant_if;
    logic       rd_done;

`ifdef ARB_RR_EN
    logic last_served;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_served <= 1'b0;
        end else if (grant_d || grant_if) begin
            last_served <= grant_d;
        end
    end
`endif

    // Grant is combinational and only possible in IDLE outside reset.
    always_comb begin
        grant_d  = 1'b0;
        grant_if = 1'b0;
        if (!rst && state == IDLE) begin
`ifdef ARB_RR_EN
            if (d_req && if_req) begin
                grant_d  = ~last_served;
                grant_if = last_served;
            end else begin
                grant_d  = d_req;
                grant_if = if_req;
            end
`else
            grant_d  = d_req;
            grant_if = if_req & ~d_req;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            owner <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            owner <= owner_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        owner_next = owner;
        case (state)
            IDLE: begin
                if (grant_d && !d_we) begin
                    state_next = RD_WAIT;
                    cnt_next   = 3'd1;
                    owner_next = 1'b1;
                end else if (grant_if) begin
                    state_next = RD_WAIT;
                    cnt_next   = 3'd1;
                    owner_next = 1'b0;
                end
            end
            RD_WAIT: begin
                if (cnt == LAT) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 3'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign rd_done = !rst && (state == RD_WAIT) && (cnt == LAT);

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if_done   = 1'b0;
        if_rdata  = '0;
        d_done    = 1'b0;
        d_rdata   = '0;
        if (grant_d) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_be    = d_be;
            d_done    = d_we;
        end else if (grant_if) begin
            mem_en   = 1'b1;
            mem_addr = if_addr;
            mem_be   = '1;
        end
        if (rd_done) begin
            if (owner) begin
                d_done  = 1'b1;
                d_rdata = mem_rdata;
            end else begin
                if_done  = 1'b1;
                if_rdata = mem_rdata;
            end
        end
        if_stall = if_req & ~if_done;
        d_stall  = d_req & ~d_done;
    end

endmodule
